// File: rtl/rect_fill.sv
// rect_fill: rasterises one rectangle command per handshake into 1-bit video RAM writes ({y,x} addressing).
module rect_fill (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [7:0]  i_x0,
  input  logic [7:0]  i_y0,
  input  logic [7:0]  i_x1,
  input  logic [7:0]  i_y1,
  input  logic        i_color,
  input  logic [1:0]  i_mode,
  input  logic        i_abort,
  output logic [15:0] o_addr,
  output logic        o_dat,
  output logic        o_we,
  output logic        o_busy,
  output logic        o_done
);
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t      state_q, state_d;
  logic [7:0]  xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic [7:0]  x_q, x_d, y_q, y_d;
  logic        color_q, color_d;
  logic [1:0]  mode_q, mode_d;
  logic [15:0] addr_q, addr_d;
  logic        dat_q, dat_d, we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic        idle, load, last, edge_px, pix_we, pix_dat, color_n;
  logic [7:0]  bxmin, bxmax, bymin, bymax, nx, ny;
  logic [1:0]  mode_n;
  // Bounds/attributes come from the inputs while idle so the first pixel can be registered at the handshake edge.
  always_comb begin
    idle    = state_q == IDLE;
    load    = idle && i_valid;
    bxmin   = idle ? ((i_x0 < i_x1) ? i_x0 : i_x1) : xmin_q;
    bxmax   = idle ? ((i_x0 < i_x1) ? i_x1 : i_x0) : xmax_q;
    bymin   = idle ? ((i_y0 < i_y1) ? i_y0 : i_y1) : ymin_q;
    bymax   = idle ? ((i_y0 < i_y1) ? i_y1 : i_y0) : ymax_q;
    color_n = idle ? i_color : color_q;
    mode_n  = idle ? i_mode : mode_q;
    last    = (x_q == xmax_q) && (y_q == ymax_q);
    nx      = load ? bxmin : ((x_q == xmax_q) ? xmin_q : x_q + 8'd1);
    ny      = load ? bymin : ((x_q == xmax_q) ? y_q + 8'd1 : y_q);
    edge_px = (nx == bxmin) || (nx == bxmax) || (ny == bymin) || (ny == bymax);
    pix_we  = (mode_n == 2'b01) ? edge_px : 1'b1;
    pix_dat = (mode_n == 2'b10) ? (color_n ^ nx[0] ^ ny[0]) : color_n;
  end
  always_comb begin
    state_d = state_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    x_d     = x_q;
    y_d     = y_q;
    color_d = color_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    dat_d   = dat_q;
    we_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (i_valid) begin
        state_d = FILL;
        xmin_d  = bxmin;
        xmax_d  = bxmax;
        ymin_d  = bymin;
        ymax_d  = bymax;
        color_d = i_color;
        mode_d  = i_mode;
        x_d     = nx;
        y_d     = ny;
        addr_d  = {ny, nx};
        dat_d   = pix_dat;
        we_d    = pix_we;
        busy_d  = 1'b1;
      end
      FILL: if (i_abort) begin
        state_d = IDLE;
      end else if (last) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        x_d    = nx;
        y_d    = ny;
        addr_d = {ny, nx};
        dat_d  = pix_dat;
        we_d   = pix_we;
        busy_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= 1'b0;
      mode_q  <= '0;
      addr_q  <= '0;
      dat_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  // The RAM samples on the edge that also sees the abort, so the pending write is masked in that same cycle.
  assign o_we    = we_q & ~((state_q == FILL) & i_abort);
  assign o_ready = state_q == IDLE;
  assign o_addr  = addr_q;
  assign o_dat   = dat_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
endmodule

// File: tb/tb_rect_fill.sv
// tb_rect_fill: directed checks of rect_fill against hand-computed write sequences and a reference frame.
module tb_rect_fill;
  logic        i_clk = 1'b0, i_rst_n = 1'b0, i_valid = 1'b0, i_color = 1'b0, i_abort = 1'b0;
  logic [7:0]  i_x0 = '0, i_y0 = '0, i_x1 = '0, i_y1 = '0;
  logic [1:0]  i_mode = '0;
  logic        o_ready, o_dat, o_we, o_busy, o_done;
  logic [15:0] o_addr;
  int vectors = 0, miscompares = 0;
  int wr_cnt = 0, done_cnt = 0, busy_cnt = 0;
  logic [16:0] wlog[$];
  bit mem [0:65535];

  rect_fill dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_x0(i_x0), .i_y0(i_y0), .i_x1(i_x1), .i_y1(i_y1),
    .i_color(i_color), .i_mode(i_mode), .i_abort(i_abort),
    .o_addr(o_addr), .o_dat(o_dat), .o_we(o_we), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (o_we) begin
      wlog.push_back({o_addr, o_dat});
      mem[o_addr] <= o_dat;
      wr_cnt <= wr_cnt + 1;
    end
    if (o_done) done_cnt <= done_cnt + 1;
    if (o_busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] x0, y0, x1, y1, input logic c, input logic [1:0] m);
    @(negedge i_clk);
    i_x0 = x0; i_y0 = y0; i_x1 = x1; i_y1 = y1; i_color = c; i_mode = m; i_valid = 1'b1;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    @(negedge i_clk);
    while (!o_ready && n < lim) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= lim) chk("idle_timeout", {31'd0, o_ready}, 32'd1);
  endtask

  initial begin
    int base, wb, db, bb, hits, errs;
    logic [15:0] exp2 [6];
    logic [3:0] dseq;
    exp2 = '{16'h0202, 16'h0203, 16'h0204, 16'h0302, 16'h0303, 16'h0304};
    repeat (3) @(negedge i_clk);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_we", {31'd0, o_we}, 32'd0);
    chk("rst_addr", {16'd0, o_addr}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_dat", {31'd0, o_dat}, 32'd0);
    i_rst_n = 1'b1;
    // 1x1 solid
    wb = wr_cnt; db = done_cnt;
    issue(8'd5, 8'd7, 8'd5, 8'd7, 1'b1, 2'b00);
    @(negedge i_clk);
    chk("p1_we", {31'd0, o_we}, 32'd1);
    chk("p1_addr", {16'd0, o_addr}, 32'h0705);
    chk("p1_dat", {31'd0, o_dat}, 32'd1);
    chk("p1_busy", {31'd0, o_busy}, 32'd1);
    chk("p1_ready", {31'd0, o_ready}, 32'd0);
    @(negedge i_clk);
    chk("p1_done", {31'd0, o_done}, 32'd1);
    chk("p1_we_off", {31'd0, o_we}, 32'd0);
    chk("p1_ready_in_done", {31'd0, o_ready}, 32'd0);
    @(negedge i_clk);
    chk("p1_ready_back", {31'd0, o_ready}, 32'd1);
    chk("p1_done_pulse", {31'd0, o_done}, 32'd0);
    chk("p1_writes", wr_cnt - wb, 32'd1);
    chk("p1_done_cnt", done_cnt - db, 32'd1);
    // swapped corners
    base = wlog.size(); wb = wr_cnt;
    issue(8'd4, 8'd3, 8'd2, 8'd2, 1'b0, 2'b00);
    wait_idle(100);
    chk("swap_writes", wr_cnt - wb, 32'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("swap_w%0d", i), {15'd0, wlog[base + i]}, {15'd0, exp2[i], 1'b0});
    // outline
    base = wlog.size(); wb = wr_cnt; bb = busy_cnt;
    issue(8'd0, 8'd0, 8'd3, 8'd3, 1'b0, 2'b01);
    wait_idle(100);
    chk("outl_fill_cycles", busy_cnt - bb, 32'd16);
    chk("outl_writes", wr_cnt - wb, 32'd12);
    hits = 0;
    for (int i = base; i < wlog.size(); i++) begin
      if (wlog[i][16:1] inside {16'h0101, 16'h0102, 16'h0201, 16'h0202}) hits++;
    end
    chk("outl_interior", hits, 32'd0);
    // checker
    base = wlog.size();
    issue(8'd0, 8'd0, 8'd1, 8'd1, 1'b1, 2'b10);
    wait_idle(100);
    chk("chk_writes", wlog.size() - base, 32'd4);
    dseq = {wlog[base][0], wlog[base + 1][0], wlog[base + 2][0], wlog[base + 3][0]};
    chk("chk_dat_seq", {28'd0, dseq}, 32'b1001);
    // reserved mode behaves as solid
    base = wlog.size();
    issue(8'd1, 8'd0, 8'd0, 8'd0, 1'b1, 2'b11);
    wait_idle(100);
    chk("rsv_w0", {15'd0, wlog[base]}, {15'd0, 16'h0000, 1'b1});
    chk("rsv_w1", {15'd0, wlog[base + 1]}, {15'd0, 16'h0001, 1'b1});
    // abort after 10 writes, with a queued command already valid
    wb = wr_cnt; db = done_cnt;
    issue(8'd0, 8'd0, 8'd15, 8'd15, 1'b1, 2'b00);
    repeat (10) @(posedge i_clk);
    #1;
    i_abort = 1'b1;
    i_x0 = 8'd9; i_y0 = 8'd9; i_x1 = 8'd9; i_y1 = 8'd9; i_color = 1'b1; i_mode = 2'b00; i_valid = 1'b1;
    @(negedge i_clk);
    chk("abort_we_masked", {31'd0, o_we}, 32'd0);
    @(posedge i_clk);
    #1 i_abort = 1'b0;
    @(negedge i_clk);
    chk("abort_ready", {31'd0, o_ready}, 32'd1);
    chk("abort_writes", wr_cnt - wb, 32'd10);
    chk("abort_no_done", done_cnt - db, 32'd0);
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    wait_idle(100);
    chk("queued_addr", {16'd0, wlog[wlog.size() - 1][16:1]}, 32'h0909);
    chk("queued_done", done_cnt - db, 32'd1);
    // async reset during fill
    issue(8'd0, 8'd0, 8'd15, 8'd15, 1'b1, 2'b00);
    repeat (3) @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_we", {31'd0, o_we}, 32'd0);
    chk("arst_busy", {31'd0, o_busy}, 32'd0);
    chk("arst_ready", {31'd0, o_ready}, 32'd1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    // full screen
    base = wlog.size(); wb = wr_cnt; db = done_cnt;
    issue(8'd255, 8'd255, 8'd0, 8'd0, 1'b1, 2'b00);
    wait_idle(70000);
    chk("full_writes", wr_cnt - wb, 32'd65536);
    chk("full_done", done_cnt - db, 32'd1);
    errs = 0;
    for (int i = 0; i < 65536 && base + i < wlog.size(); i++) begin
      if (wlog[base + i][16:1] != 16'(i)) errs++;
    end
    chk("full_contig", errs, 32'd0);
    hits = 0;
    for (int i = 0; i < 65536; i++) if (mem[i]) hits++;
    chk("full_mem_ones", hits, 32'd65536);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
